// File: rtl/sa_feeder.sv
// Input staging for the 3x3 systolic array: weight preload, diagonally skewed activations, drain/done.
// Optional SA_FEEDER_BEAT_CNT_EN adds a saturating 16-bit accepted-activation counter (beat_cnt).
module sa_feeder #(
   parameter int unsigned DW        = 8,
   parameter int unsigned NVEC      = 3,
   parameter int unsigned ARRAY_LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   input  logic [3*DW-1:0] in_data,
   output logic            in_ready,
   output logic [DW-1:0]   a_out_1,
   output logic [DW-1:0]   a_out_2,
   output logic [DW-1:0]   a_out_3,
   output logic [DW-1:0]   b_out_1,
   output logic [DW-1:0]   b_out_2,
   output logic [DW-1:0]   b_out_3,
   output logic            b_en,
   output logic            busy,
`ifdef SA_FEEDER_BEAT_CNT_EN
   output logic [15:0]     beat_cnt,
`endif
   output logic            done
);

   localparam int unsigned DRAIN_CYC = 2 + ARRAY_LAT;
   localparam int unsigned DCW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [1:0]     wcnt;
   logic [7:0]     acnt;
   logic [DCW-1:0] dcnt;
   logic           accept;
   logic           wt_acc;
   logic           act_acc;
   logic           enter_load;
   logic           in_ready_nxt;
   logic           busy_nxt;
   logic           done_nxt;
   logic [DW-1:0]  a2_s;
   logic [DW-1:0]  a3_s0;
   logic [DW-1:0]  a3_s1;

   assign accept     = in_valid & in_ready;
   assign wt_acc     = accept & (state == S_LOAD_B);
   assign act_acc    = accept & (state == S_STREAM);
   assign enter_load = (state_nxt == S_LOAD_B) && (state != S_LOAD_B);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_LOAD_B;
         S_LOAD_B: if (wt_acc && (wcnt == 2'd2)) state_nxt = S_STREAM;
         S_STREAM: if (act_acc && (acnt == 8'(NVEC - 1))) state_nxt = S_DRAIN;
         S_DRAIN:  if (dcnt == DCW'(DRAIN_CYC - 1)) state_nxt = S_DONE;
         S_DONE:   state_nxt = start ? S_LOAD_B : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the upcoming state so they can be registered
   always_comb begin
      in_ready_nxt = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      unique case (state_nxt)
         S_LOAD_B, S_STREAM: begin
            in_ready_nxt = 1'b1;
            busy_nxt     = 1'b1;
         end
         S_DRAIN: busy_nxt = 1'b1;
         S_DONE:  done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         in_ready <= in_ready_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   // Tile counters, cleared whenever a new tile begins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt <= '0;
         acnt <= '0;
         dcnt <= '0;
      end else if (enter_load) begin
         wcnt <= '0;
         acnt <= '0;
         dcnt <= '0;
      end else begin
         if (wt_acc)              wcnt <= wcnt + 2'd1;
         if (act_acc)             acnt <= acnt + 8'd1;
         if (state == S_DRAIN)    dcnt <= dcnt + DCW'(1);
      end
   end

   // Weights pass straight through for one cycle; zero otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b_en    <= 1'b0;
         b_out_1 <= '0;
         b_out_2 <= '0;
         b_out_3 <= '0;
      end else begin
         b_en    <= wt_acc;
         b_out_1 <= wt_acc ? in_data[DW-1:0]      : '0;
         b_out_2 <= wt_acc ? in_data[2*DW-1:DW]   : '0;
         b_out_3 <= wt_acc ? in_data[3*DW-1:2*DW] : '0;
      end
   end

   // Free-running skew chain: lane k sees its data k cycles after acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_out_1 <= '0;
         a2_s    <= '0;
         a_out_2 <= '0;
         a3_s0   <= '0;
         a3_s1   <= '0;
         a_out_3 <= '0;
      end else begin
         a_out_1 <= act_acc ? in_data[DW-1:0]      : '0;
         a2_s    <= act_acc ? in_data[2*DW-1:DW]   : '0;
         a_out_2 <= a2_s;
         a3_s0   <= act_acc ? in_data[3*DW-1:2*DW] : '0;
         a3_s1   <= a3_s0;
         a_out_3 <= a3_s1;
      end
   end

`ifdef SA_FEEDER_BEAT_CNT_EN
   // Lifetime activation count, saturating, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               beat_cnt <= '0;
      else if (act_acc && (beat_cnt != 16'hFFFF)) beat_cnt <= beat_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: directed vector table, corner sequences and a random run
// checked against a tile-level reference model. Honours SA_FEEDER_BEAT_CNT_EN when defined.
module tb_sa_feeder;

   localparam int unsigned DW        = 8;
   localparam int unsigned NVEC      = 3;
   localparam int unsigned ARRAY_LAT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [23:0]   in_data = '0;
   logic          in_ready;
   logic [DW-1:0] a_out_1, a_out_2, a_out_3;
   logic [DW-1:0] b_out_1, b_out_2, b_out_3;
   logic          b_en, busy, done;
`ifdef SA_FEEDER_BEAT_CNT_EN
   logic [15:0]   beat_cnt;
`endif

   sa_feeder #(.DW(DW), .NVEC(NVEC), .ARRAY_LAT(ARRAY_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .a_out_1  (a_out_1),
      .a_out_2  (a_out_2),
      .a_out_3  (a_out_3),
      .b_out_1  (b_out_1),
      .b_out_2  (b_out_2),
      .b_out_3  (b_out_3),
      .b_en     (b_en),
      .busy     (busy),
`ifdef SA_FEEDER_BEAT_CNT_EN
      .beat_cnt (beat_cnt),
`endif
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tile phase (0 idle,1 weights,2 activations,3 drain,4 done) plus
   // history of what was accepted at the last three edges.
   int          m_phase;
   int          m_cnt;
   int          m_beats;
   logic [23:0] m_act [3];
   logic [23:0] m_w;
   logic        m_wen;

   task automatic model_reset();
      m_phase = 0;
      m_cnt   = 0;
      m_beats = 0;
      for (int i = 0; i < 3; i++) m_act[i] = '0;
      m_w   = '0;
      m_wen = 1'b0;
   endtask

   task automatic model_edge();
      logic acc;
      acc      = in_valid && (m_phase == 1 || m_phase == 2);
      m_act[2] = m_act[1];
      m_act[1] = m_act[0];
      m_act[0] = (acc && m_phase == 2) ? in_data : 24'h0;
      m_wen    = acc && (m_phase == 1);
      m_w      = m_wen ? in_data : 24'h0;
      if (acc && m_phase == 2 && m_beats < 65535) m_beats++;
      case (m_phase)
         0: if (start) begin m_phase = 1; m_cnt = 0; end
         1: if (acc) begin
               m_cnt++;
               if (m_cnt == 3) begin m_phase = 2; m_cnt = 0; end
            end
         2: if (acc) begin
               m_cnt++;
               if (m_cnt == int'(NVEC)) begin m_phase = 3; m_cnt = 0; end
            end
         3: begin
               m_cnt++;
               if (m_cnt == int'(2 + ARRAY_LAT)) m_phase = 4;
            end
         default: begin m_phase = start ? 1 : 0; m_cnt = 0; end
      endcase
   endtask

   task automatic check_model();
      cmp("in_ready", 32'(in_ready), 32'(m_phase == 1 || m_phase == 2));
      cmp("busy",     32'(busy),     32'(m_phase >= 1 && m_phase <= 3));
      cmp("done",     32'(done),     32'(m_phase == 4));
      cmp("a_out_1",  32'(a_out_1),  32'(m_act[0][7:0]));
      cmp("a_out_2",  32'(a_out_2),  32'(m_act[1][15:8]));
      cmp("a_out_3",  32'(a_out_3),  32'(m_act[2][23:16]));
      cmp("b_en",     32'(b_en),     32'(m_wen));
      cmp("b_out",    {8'h0, b_out_3, b_out_2, b_out_1}, {8'h0, m_w});
`ifdef SA_FEEDER_BEAT_CNT_EN
      cmp("beat_cnt", 32'(beat_cnt), 32'(m_beats));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   // Full tile; latency is the cycle (relative to the start edge) in which done is seen
   task automatic run_tile(input bit do_start, input int bubble_after, input int bubble_len,
                           output int lat);
      int cyc;
      if (do_start) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      cyc = 1;
      for (int w = 0; w < 3; w++) begin
         in_valid = 1'b1; in_data = 24'($urandom); step(); cyc++;
      end
      for (int a = 0; a < int'(NVEC); a++) begin
         if (a == bubble_after) begin
            for (int b = 0; b < bubble_len; b++) begin
               in_valid = 1'b0; step(); cyc++;
            end
         end
         in_valid = 1'b1; in_data = 24'($urandom); step(); cyc++;
      end
      in_valid = 1'b0;
      while (!done && cyc < 60) begin step(); cyc++; end
      if (!done) cmp("done_timeout", 32'(done), 32'd1);
      lat = cyc;
   endtask

   typedef struct {
      logic        st;
      logic        v;
      logic [23:0] d;
      logic        rdy, bsy, dn, ben;
      logic [7:0]  a1, a2, a3;
      logic [23:0] b;
   } vec_t;

   vec_t tbl [13];
   int   lat;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h000000};
      tbl[1]  = '{1'b0, 1'b1, 24'h030201, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 24'h030201};
      tbl[2]  = '{1'b0, 1'b1, 24'h060504, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 24'h060504};
      tbl[3]  = '{1'b0, 1'b1, 24'h090807, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 24'h090807};
      tbl[4]  = '{1'b0, 1'b1, 24'h312111, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 24'h000000};
      tbl[5]  = '{1'b1, 1'b1, 24'h322212, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h21, 8'h00, 24'h000000};
      tbl[6]  = '{1'b0, 1'b1, 24'h332313, 1'b0, 1'b1, 1'b0, 1'b0, 8'h13, 8'h22, 8'h31, 24'h000000};
      tbl[7]  = '{1'b0, 1'b1, 24'h999999, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h23, 8'h32, 24'h000000};
      tbl[8]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h33, 24'h000000};
      tbl[9]  = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h000000};
      tbl[10] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h000000};
      tbl[11] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 24'h000000};
      tbl[12] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h000000};

      model_reset();
      #2;
      check_model();
      #10 rst = 1'b1;

      // No start: valid beats must be held off
      in_valid = 1'b1; in_data = 24'hABCDEF;
      for (int i = 0; i < 3; i++) begin
         step();
         cmp("idle_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      // Directed zero-stall tile with start collisions in STREAM and DRAIN
      for (int i = 0; i < 13; i++) begin
         start = tbl[i].st; in_valid = tbl[i].v; in_data = tbl[i].d;
         step();
         cmp($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         cmp($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].bsy));
         cmp($sformatf("tbl%0d_done", i),  32'(done),     32'(tbl[i].dn));
         cmp($sformatf("tbl%0d_b_en", i),  32'(b_en),     32'(tbl[i].ben));
         cmp($sformatf("tbl%0d_a", i), {8'h0, a_out_3, a_out_2, a_out_1},
             {8'h0, tbl[i].a3, tbl[i].a2, tbl[i].a1});
         cmp($sformatf("tbl%0d_b", i), {8'h0, b_out_3, b_out_2, b_out_1}, {8'h0, tbl[i].b});
      end
      start = 1'b0; in_valid = 1'b0;

      run_tile(1'b1, -1, 0, lat);
      cmp("lat_nostall", 32'(lat), 32'd12);
      run_tile(1'b1, 1, 2, lat);
      cmp("lat_bubble", 32'(lat), 32'd14);

      // start in the DONE cycle goes straight to LOAD_B
      start = 1'b1;
      step();
      start = 1'b0;
      cmp("done_start_busy", 32'(busy), 32'd1);
      cmp("done_start_ready", 32'(in_ready), 32'd1);
      run_tile(1'b0, -1, 0, lat);
      cmp("lat_restart", 32'(lat), 32'd12);
      step();

      // Asynchronous reset in the middle of a tile
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 24'($urandom); step();
      end
      #3 rst = 1'b0;
      #1;
      model_reset();
      check_model();
      cmp("rst_outs", {a_out_1, a_out_2, a_out_3, b_out_1}, 32'd0);
      @(posedge clk); #1;
      check_model();
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         cmp("post_rst_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      run_tile(1'b1, -1, 0, lat);
      run_tile(1'b1, 0, 1, lat);
`ifdef SA_FEEDER_BEAT_CNT_EN
      cmp("beat_cnt_two_tiles", 32'(beat_cnt), 32'd6);
`endif

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         start    = ($urandom_range(0, 7) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 24'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
